dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised data-memory controller between the mips core and a byte-enable synchronous RAM.
//  Adds byte/half/word loads and stores with sign/zero extension.
//  Adds configurable wait states and a stall handshake so the core can tolerate multi-cycle memory.
//  Replaces the direct core-to-data_mem hookup in the top level.
// PARAMETERS
//  ADDR_W       32    core byte-address width
//  DEPTH_WORDS  1024  RAM depth in 32-bit words (power of 2)
//  LATENCY      1     extra wait cycles before the RAM access (0..7)
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous reset, ACTIVE-LOW (0 = reset)
//  mem_read   in   1       load request; held stable while stall=1
//  mem_write  in   1       store request; held stable while stall=1
//  addr       in   ADDR_W  byte address (ALU result)
//  size       in   2       00 byte, 01 half, 10 word (11 treated as word)
//  sign_ext   in   1       1 = sign-extend sub-word loads, 0 = zero-extend
//  wdata      in   32      store data, right-aligned (rt)
//  rdata      out  32      load data, aligned and extended; valid when done=1
//  stall      out  1       freeze core: (mem_read|mem_write) & ~done, forced 0 in reset
//  done       out  1       one-cycle completion pulse
//  addr_err   out  1       misaligned access flag, valid with done (see CONFIGURATION)
// BEHAVIOUR
//  FSM: IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
//  - IDLE with request at edge: latch addr/size/sign_ext/lanes. Go to WAIT with cnt=LATENCY-1, or straight to ACCESS if LATENCY=0.
//  - WAIT: decrement cnt; go to ACCESS when cnt=0.
//  - ACCESS: one RAM cycle. Store commits with byte enables; load data is registered.
//  - RESP: done=1, stall=0, rdata valid. Always return to IDLE; the request present in RESP is not re-accepted.
//  Latency: request first seen in cycle N -> done in cycle N+LATENCY+2. Next request is accepted at N+LATENCY+3.
//  Lanes: little-endian, lane = addr[1:0].
//  - Byte store: be = 4'b0001<<addr[1:0], wdata[7:0] replicated to all lanes.
//  - Half store: be = 4'b0011<<{addr[1],1'b0}, wdata[15:0] replicated. Word store: be = 4'b1111.
//  - Loads: select the lane(s), then extend per sign_ext to 32 bits.
//  Index = addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so accesses wrap/alias.
//  mem_read & mem_write together: treated as a store, rdata=0.
//  rdata holds its last value outside RESP. Stores return rdata=0.
//  Reset (rst=0 at an edge) in any state: FSM -> IDLE.
//  - A store in ACCESS during that edge is NOT committed.
//  - RAM contents are not cleared.
//  Reset values: rdata=0, done=0, addr_err=0, stall=0, cnt=0.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) skips WAIT and ACCESS. IDLE -> RESP.
//  - In RESP: done=1, addr_err=1, rdata=0; RAM is untouched.
//  DMEM_ALIGN_CHECK_EN undefined:
//  - addr_err tied 0.
//  - Low address bits are forced to 0 for half/word, and the access proceeds normally.
// STRUCTURE
//  Package dmem_pkg holds:
//  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
//  - FSM state encodings ST_IDLE/ST_WAIT/ST_ACCESS/ST_RESP
//  - lane/extend helper functions
//  Sub-module dmem_bram: DEPTH_WORDS x 32 single-port RAM with 4-bit byte write enable and registered read.
//  FSM, counter and lane logic live in dmem_ctrl.
// TESTING
//  1. LATENCY=1. sw 0xDEADBEEF @0x10 -> done in cycle N+3, stall high 3 cycles. lw @0x10 -> rdata=0xDEADBEEF.
//  2. sb 0x80 @0x13, then:
//     - lb @0x13 -> 0xFFFFFF80
//     - lbu @0x13 -> 0x00000080
//     - lw @0x10 -> 0x80ADBEEF
//  3. sh 0x1234 @0x12 -> lw @0x10 = 0x1234BEEF. lh @0x12 sign -> 0x00001234.
//  4. LATENCY=3. lw -> stall=1 for 5 cycles, done in cycle N+5. rst=0 during WAIT of sw 0x55 @0x20 -> IDLE next cycle, lw @0x20 unchanged.
//  5. DEPTH_WORDS=1024. sw 0xCAFEF00D @0x1010 -> lw @0x10 = 0xCAFEF00D (wrap).
//  6. With DMEM_ALIGN_CHECK_EN: lh @0x11 -> done in cycle N+1 with addr_err=1, rdata=0, memory unchanged.
//     Without it: the same lh reads half @0x10, addr_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory controller: size codes,
//            FSM state encoding, and lane / byte-enable / extension helpers.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << lane;
      SZ_HALF: lane_be = 4'b0011 << {lane[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every lane carries the right bytes;
  // the byte enables then pick the lane(s) actually written.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Select the addressed lane(s) of a RAM word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic [1:0] lane,
                                              input logic sx, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: load_extend = {{24{sx & b[7]}}, b};
      SZ_HALF: load_extend = {{16{sx & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      default: misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bram
// Purpose  : DEPTH_WORDS x 32 single-port RAM, per-byte write enable,
//            registered read (read-before-write on the same cycle).
// Ports    : clk      clock
//            i_en     access enable (read and/or write this cycle)
//            i_we     byte write enables, bit n writes bits [8n+7:8n]
//            i_idx    word index
//            i_wdata  write data
//            o_rdata  registered read data, valid the cycle after i_en
// Revision : 1.0  initial release
// ============================================================================
module dmem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [3:0]       i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  // No reset: RAM contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Data-memory controller between the core and a byte-enable RAM.
//            Byte/half/word loads and stores, sign/zero extension, LATENCY
//            wait states and a stall handshake.
// Config   : DMEM_ALIGN_CHECK_EN - when defined, misaligned half/word accesses
//            complete immediately with addr_err=1 and do not touch the RAM;
//            otherwise their low address bits are forced to zero.
// Ports    : clk, rst (sync, active-low)
//            mem_read, mem_write, addr, size, sign_ext, wdata  - request
//            rdata, stall, done, addr_err                      - response
// Revision : 1.0  initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              addr_err
);

  localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [2:0] c_CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_t               r_state, w_next;
  logic [2:0]           r_cnt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [1:0]           r_lane, r_size;
  logic                 r_sign, r_wr, r_err;
  logic [31:0]          r_rdata;

  logic                 w_req, w_misal, w_resp;
  logic [1:0]           w_lane;
  logic [31:0]          w_ram_q, w_resp_data;
  logic [3:0]           w_we;
  logic                 w_unused_addr;

  // Upper address bits alias onto the RAM.
  assign w_unused_addr = ^addr[ADDR_W-1:c_IDX_W+2];

  assign w_req = mem_read | mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misal = misaligned(size, addr[1:0]);
  assign w_lane  = addr[1:0];
`else
  assign w_misal = 1'b0;
  always_comb begin
    w_lane = addr[1:0];
    if (size == SZ_HALF)      w_lane[0] = 1'b0;
    else if (size != SZ_BYTE) w_lane    = 2'b00;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_misal)           w_next = ST_RESP;
          else if (LATENCY == 0) w_next = ST_ACCESS;
          else                   w_next = ST_WAIT;
        end
      end
      ST_WAIT:   if (r_cnt == 3'd0) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;   // request still held here is not re-taken
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, held read data
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_size  <= SZ_BYTE;
      r_sign  <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_cnt  <= c_CNT_INIT;
        r_idx  <= addr[2 +: c_IDX_W];
        r_lane <= w_lane;
        r_size <= size;
        r_sign <= sign_ext;
        r_wr   <= mem_write;
        r_err  <= w_misal;
      end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_resp) r_rdata <= w_resp_data;
    end
  end

  // Gating with rst keeps a store in ACCESS from committing on a reset edge.
  assign w_we = (r_state == ST_ACCESS && r_wr && rst) ? lane_be(r_size, r_lane) : 4'b0000;

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_bram (
    .clk     (clk),
    .i_en    (r_state == ST_ACCESS),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (store_data(r_size, wdata)),
    .o_rdata (w_ram_q)
  );

  assign w_resp      = (r_state == ST_RESP);
  assign w_resp_data = (r_wr || r_err) ? 32'd0 : load_extend(r_size, r_lane, r_sign, w_ram_q);

  assign rdata    = w_resp ? w_resp_data : r_rdata;
  assign done     = w_resp;
  assign addr_err = w_resp & r_err;
  assign stall    = rst & w_req & ~w_resp;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Self-checking bench for dmem_ctrl. Instance 0 runs LATENCY=1,
//            instance 1 runs LATENCY=3; a byte-array model checks random
//            traffic on instance 0. Honours DMEM_ALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       mr, mw, sx;
  logic [1:0][31:0] ad, wd;
  logic [1:0][1:0]  sz;
  logic [31:0]      rd0, rd1;
  logic             st0, st1, dn0, dn1, ae0, ae1;
  logic [1:0][31:0] rd;
  logic [1:0]       st, dn, ae;

  assign rd = {rd1, rd0};
  assign st = {st1, st0};
  assign dn = {dn1, dn0};
  assign ae = {ae1, ae0};

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst_n), .mem_read(mr[0]), .mem_write(mw[0]), .addr(ad[0]),
    .size(sz[0]), .sign_ext(sx[0]), .wdata(wd[0]), .rdata(rd0), .stall(st0),
    .done(dn0), .addr_err(ae0));

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst_n), .mem_read(mr[1]), .mem_write(mw[1]), .addr(ad[1]),
    .size(sz[1]), .sign_ext(sx[1]), .wdata(wd[1]), .rdata(rd1), .stall(st1),
    .done(dn1), .addr_err(ae1));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: returns rdata/addr_err at done, cycles to done, stall cycles.
  task automatic xact(input int u, input logic w, input logic r, input logic [31:0] a,
                      input logic [1:0] s, input logic x, input logic [31:0] d,
                      output logic [31:0] q, output logic e, output int cyc, output int stc);
    @(negedge clk);
    mr[u] = r; mw[u] = w; ad[u] = a; sz[u] = s; sx[u] = x; wd[u] = d;
    cyc = 0; stc = 0;
    #1;
    while (dn[u] !== 1'b1 && cyc < 40) begin
      if (st[u] === 1'b1) stc++;
      @(negedge clk); #1;
      cyc++;
    end
    q = rd[u];
    e = ae[u];
    check("stall_in_resp", 32'(st[u]), 32'd0);
    mr[u] = 1'b0; mw[u] = 1'b0;
  endtask

  // Byte-addressed reference memory (low 12 address bits = 1024 words).
  logic [7:0] m0 [4096];

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic void mstore(input logic [31:0] a, input int n, input logic [31:0] d);
    int base = int'(a[11:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) m0[(base + i) & 4095] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input int n, input logic x);
    logic [31:0] v;
    int base = int'(a[11:0]) & ~(n - 1);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(m0[(base + i) & 4095]) << (8 * i));
    if (x && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, a, d, eq;
    logic        e, x, mis;
    int          cyc, stc, op, n, ecyc;
    logic [1:0]  s;

    mr = '0; mw = '0; sx = '0; ad = '0; wd = '0; sz = '0;
    rst_n = 1'b0;
    mr[0] = 1'b1;                       // request during reset must not stall
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_stall", 32'(st0), 32'd0);
    check("rst_done", 32'(dn0), 32'd0);
    check("rst_rdata", rd0, 32'd0);
    check("rst_err", 32'(ae0), 32'd0);
    mr[0] = 1'b0;
    rst_n = 1'b1;

    // Word store / load, LATENCY=1
    xact(0, 1, 0, 32'h10, SZ_WORD, 0, 32'hDEADBEEF, q, e, cyc, stc);
    check("sw_cyc", 32'(cyc), 32'(LAT0 + 2));
    check("sw_stall", 32'(stc), 32'd3);
    check("sw_rdata", q, 32'd0);
    xact(0, 0, 1, 32'h10, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("lw_rdata", q, 32'hDEADBEEF);
    @(negedge clk); #1;
    check("rdata_hold", rd0, 32'hDEADBEEF);
    check("done_pulse", 32'(dn0), 32'd0);

    // Byte store and loads
    xact(0, 1, 0, 32'h13, SZ_BYTE, 0, 32'h00000080, q, e, cyc, stc);
    xact(0, 0, 1, 32'h13, SZ_BYTE, 1, 0, q, e, cyc, stc);
    check("lb", q, 32'hFFFFFF80);
    xact(0, 0, 1, 32'h13, SZ_BYTE, 0, 0, q, e, cyc, stc);
    check("lbu", q, 32'h00000080);
    xact(0, 0, 1, 32'h10, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("lw_after_sb", q, 32'h80ADBEEF);

    // Half store
    xact(0, 1, 0, 32'h12, SZ_HALF, 0, 32'h00001234, q, e, cyc, stc);
    xact(0, 0, 1, 32'h10, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("lw_after_sh", q, 32'h1234BEEF);
    xact(0, 0, 1, 32'h12, SZ_HALF, 1, 0, q, e, cyc, stc);
    check("lh", q, 32'h00001234);

    // Wrap / alias
    xact(0, 1, 0, 32'h1010, SZ_WORD, 0, 32'hCAFEF00D, q, e, cyc, stc);
    xact(0, 0, 1, 32'h10, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("wrap", q, 32'hCAFEF00D);

    // Misaligned half
    xact(0, 0, 1, 32'h11, SZ_HALF, 1, 0, q, e, cyc, stc);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_cyc", 32'(cyc), 32'd1);
    check("mis_err", 32'(e), 32'd1);
    check("mis_rdata", q, 32'd0);
    xact(0, 1, 0, 32'h12, SZ_WORD, 0, 32'h11111111, q, e, cyc, stc);
    check("mis_sw_err", 32'(e), 32'd1);
    xact(0, 0, 1, 32'h10, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("mis_mem", q, 32'hCAFEF00D);
`else
    check("mis_cyc", 32'(cyc), 32'(LAT0 + 2));
    check("mis_err", 32'(e), 32'd0);
    check("mis_rdata", q, 32'hFFFFF00D);
`endif

    // LATENCY=3 instance
    xact(1, 1, 0, 32'h20, SZ_WORD, 0, 32'h11111111, q, e, cyc, stc);
    check("l3_sw_cyc", 32'(cyc), 32'(LAT1 + 2));
    xact(1, 0, 1, 32'h20, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("l3_lw_cyc", 32'(cyc), 32'd5);
    check("l3_lw_stall", 32'(stc), 32'd5);
    check("l3_lw_rdata", q, 32'h11111111);

    // Reset during WAIT of a store
    @(negedge clk);
    mw[1] = 1'b1; ad[1] = 32'h20; wd[1] = 32'h55; sz[1] = SZ_WORD;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rstw_stall", 32'(st1), 32'd0);
    check("rstw_done", 32'(dn1), 32'd0);
    mw[1] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rstw_idle", 32'(dn1), 32'd0);
    xact(1, 0, 1, 32'h20, SZ_WORD, 0, 0, q, e, cyc, stc);
    check("rstw_mem", q, 32'h11111111);

    // Random traffic on instance 0: seed a 64-word window, then mix ops.
    for (int w = 0; w < 64; w++) begin
      a = ($urandom & 32'hFFFFF000) | 32'(w * 4);
      d = $urandom;
      xact(0, 1, 0, a, SZ_WORD, 0, d, q, e, cyc, stc);
      mstore(a, 4, d);
    end
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 2);
      s  = 2'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      x  = 1'($urandom);
      d  = $urandom;
      n  = nbytes(s);
`ifdef DMEM_ALIGN_CHECK_EN
      mis = (n > 1) && ((int'(a[1:0]) % n) != 0);
`else
      mis = 1'b0;
`endif
      ecyc = mis ? 1 : LAT0 + 2;
      if (op == 0) eq = mis ? 32'd0 : mload(a, n, x);
      else         eq = 32'd0;
      xact(0, op != 0, op != 1, a, s, x, d, q, e, cyc, stc);
      if (op != 0 && !mis) mstore(a, n, d);
      check("rnd_rdata", q, eq);
      check("rnd_err", 32'(e), 32'(mis));
      check("rnd_cyc", 32'(cyc), 32'(ecyc));
      check("rnd_stall", 32'(stc), 32'(ecyc));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
